// File: rtl/enc_chan_sel.sv
// Encoder-to-ADC-channel selector: accumulates cw/ccw detents into channel steps
// and holds a settle window after each change. Define ENC_CHAN_LOAD_EN for direct channel loads.
module enc_chan_sel #(
  parameter int NUM_CHAN         = 8,
  parameter int DETENTS_PER_STEP = 4,
  parameter int WRAP_EN          = 1,
  parameter int SETTLE_CYCLES    = 16,
  localparam int CHW = (NUM_CHAN > 2) ? $clog2(NUM_CHAN) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cw,
  input  logic           ccw,
`ifdef ENC_CHAN_LOAD_EN
  input  logic           load_en,
  input  logic [CHW-1:0] load_chan,
`endif
  output logic [CHW-1:0] chan,
  output logic           chan_changed,
  output logic           chan_dir,
  output logic           chan_settled,
  output logic           enc_conflict
);

  localparam int ACCW = $clog2(DETENTS_PER_STEP) + 2;
  localparam logic signed [ACCW-1:0] ACC_ONE = ACCW'(1);
  localparam logic signed [ACCW-1:0] ACC_UP  = ACCW'(DETENTS_PER_STEP);
  localparam logic signed [ACCW-1:0] ACC_DN  = -ACC_UP;
  localparam logic [CHW-1:0] CHAN_MAX    = CHW'(NUM_CHAN - 1);
  localparam logic [15:0]    SETTLE_LOAD = 16'(SETTLE_CYCLES);
  localparam logic           SETTLE_NONE = (SETTLE_CYCLES == 0);

  logic signed [ACCW-1:0] r_acc;
  logic [CHW-1:0]         r_chan;
  logic                   r_changed;
  logic                   r_dir;
  logic                   r_settled;
  logic                   r_conflict;
  logic [15:0]            r_settle_cnt;

  logic                   w_load_ok;
  logic [CHW-1:0]         w_load_chan;
  logic signed [ACCW-1:0] w_acc_step;
  logic signed [ACCW-1:0] w_acc_next;
  logic [CHW-1:0]         w_chan_next;
  logic                   w_dir_next;
  logic                   w_chan_diff;
  logic                   w_reload;

`ifdef ENC_CHAN_LOAD_EN
  // Out-of-range loads fall through so the encoder still gets its cycle.
  assign w_load_ok   = load_en && (int'(load_chan) < NUM_CHAN);
  assign w_load_chan = load_chan;
`else
  assign w_load_ok   = 1'b0;
  assign w_load_chan = '0;
`endif

  // NOTE: every signal gets a default before any branch, so no path leaves one unassigned (no latch).
  always_comb begin
    w_acc_step  = r_acc;
    w_acc_next  = r_acc;
    w_chan_next = r_chan;
    w_dir_next  = r_dir;
    w_reload    = 1'b0;

    if (cw && !ccw)      w_acc_step = r_acc + ACC_ONE;
    else if (ccw && !cw) w_acc_step = r_acc - ACC_ONE;
    w_acc_next = w_acc_step;

    if (w_load_ok) begin
      w_acc_next  = '0;
      w_chan_next = w_load_chan;
      w_dir_next  = (w_load_chan > r_chan);
      w_reload    = 1'b1;
    end else if (w_acc_step == ACC_UP) begin
      w_acc_next = '0;
      w_dir_next = 1'b1;
      if (r_chan < CHAN_MAX)  w_chan_next = r_chan + 1'b1;
      else if (WRAP_EN != 0)  w_chan_next = '0;
    end else if (w_acc_step == ACC_DN) begin
      w_acc_next = '0;
      w_dir_next = 1'b0;
      if (r_chan != '0)       w_chan_next = r_chan - 1'b1;
      else if (WRAP_EN != 0)  w_chan_next = CHAN_MAX;
    end

    w_chan_diff = (w_chan_next != r_chan);
    if (w_chan_diff) w_reload = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc        <= '0;
      r_chan       <= '0;
      r_changed    <= 1'b0;
      r_dir        <= 1'b1;
      r_conflict   <= 1'b0;
      r_settle_cnt <= SETTLE_LOAD;
      r_settled    <= SETTLE_NONE;
    end else begin
      r_acc     <= w_acc_next;
      r_chan    <= w_chan_next;
      r_dir     <= w_dir_next;
      r_changed <= w_chan_diff;
      if (cw && ccw) r_conflict <= 1'b1;

      // A new change restarts the window even if one is already running.
      if (w_reload) begin
        r_settle_cnt <= SETTLE_LOAD;
        r_settled    <= SETTLE_NONE;
      end else if (r_settle_cnt != '0) begin
        r_settle_cnt <= r_settle_cnt - 16'd1;
        if (r_settle_cnt == 16'd1) r_settled <= 1'b1;
      end
    end
  end

  assign chan         = r_chan;
  assign chan_changed = r_changed;
  assign chan_dir     = r_dir;
  assign chan_settled = r_settled;
  assign enc_conflict = r_conflict;

endmodule

// File: tb/tb_enc_chan_sel.sv
// Scoreboard bench for enc_chan_sel: a default-parameter instance plus a saturating
// 9-channel instance (which also carries the optional load ports when enabled).
module tb_enc_chan_sel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       m_cw = 1'b0, m_ccw = 1'b0, s_cw = 1'b0, s_ccw = 1'b0;
  logic [2:0] m_chan;
  logic       m_changed, m_dir, m_settled, m_conflict;
  logic [3:0] s_chan;
  logic       s_changed, s_dir, s_settled, s_conflict;
`ifdef ENC_CHAN_LOAD_EN
  logic       m_load_en = 1'b0;
  logic [2:0] m_load_chan = '0;
  logic       s_load_en = 1'b0;
  logic [3:0] s_load_chan = '0;
`endif

  int total = 0;
  int bad   = 0;
  logic [8:0] q_m[$];
  logic [8:0] q_s[$];

  enc_chan_sel u_dut (
    .clk(clk), .reset(reset), .cw(m_cw), .ccw(m_ccw),
`ifdef ENC_CHAN_LOAD_EN
    .load_en(m_load_en), .load_chan(m_load_chan),
`endif
    .chan(m_chan), .chan_changed(m_changed), .chan_dir(m_dir),
    .chan_settled(m_settled), .enc_conflict(m_conflict)
  );

  enc_chan_sel #(.NUM_CHAN(9), .WRAP_EN(0)) u_sat (
    .clk(clk), .reset(reset), .cw(s_cw), .ccw(s_ccw),
`ifdef ENC_CHAN_LOAD_EN
    .load_en(s_load_en), .load_chan(s_load_chan),
`endif
    .chan(s_chan), .chan_changed(s_changed), .chan_dir(s_dir),
    .chan_settled(s_settled), .enc_conflict(s_conflict)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pulse to the selected instance(s), then gap idle cycles.
  task automatic pulse(input logic c, input logic a, input bit to_m, input bit to_s, input int gap);
    if (to_m) begin m_cw = c; m_ccw = a; end
    if (to_s) begin s_cw = c; s_ccw = a; end
    tick();
    m_cw = 1'b0; m_ccw = 1'b0; s_cw = 1'b0; s_ccw = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard monitors: each chan_changed pulse must match the next queued {dir, chan}.
  always @(negedge clk) begin : mon_m
    logic [8:0] e;
    if (!reset && m_changed) begin
      if (q_m.size() == 0) begin
        total++; bad++;
        $display("FAIL main_unexpected_change: chan=%0d dir=%0d, required no change", m_chan, m_dir);
      end else begin
        e = q_m.pop_front();
        check("main_change", {23'd0, m_dir, 5'd0, m_chan}, {23'd0, e});
      end
    end
  end

  always @(negedge clk) begin : mon_s
    logic [8:0] e;
    if (!reset && s_changed) begin
      if (q_s.size() == 0) begin
        total++; bad++;
        $display("FAIL sat_unexpected_change: chan=%0d dir=%0d, required no change", s_chan, s_dir);
      end else begin
        e = q_s.pop_front();
        check("sat_change", {23'd0, s_dir, 4'd0, s_chan}, {23'd0, e});
      end
    end
  end

  initial begin
    repeat (3) tick();
    check("rst_chan", m_chan, 0);
    check("rst_changed", m_changed, 0);
    check("rst_dir", m_dir, 1);
    check("rst_settled", m_settled, 0);
    check("rst_conflict", m_conflict, 0);
    check("rst_sat_chan", s_chan, 0);
    reset = 1'b0;

    // 4 cw, one per 3 clk: step on the 4th pulse, then a 16-cycle settle window.
    repeat (3) pulse(1, 0, 1, 0, 2);
    q_m.push_back({1'b1, 8'd1});
    pulse(1, 0, 1, 0, 0);
    check("t1_chan", m_chan, 1);
    check("t1_dir", m_dir, 1);
    check("t1_settled_low", m_settled, 0);
    tick();
    check("t1_changed_one_cycle", m_changed, 0);
    repeat (14) tick();
    check("t1_settled_still_low", m_settled, 0);
    tick();
    check("t1_settled_high", m_settled, 1);

    // 4 ccw from 0: main wraps to 7, saturating instance holds at 0.
    do_reset();
    repeat (3) pulse(0, 1, 1, 1, 1);
    q_m.push_back({1'b0, 8'd7});
    pulse(0, 1, 1, 1, 1);
    check("t2_wrap_chan", m_chan, 7);
    check("t2_wrap_dir", m_dir, 0);
    check("t2_sat_chan", s_chan, 0);
    check("t2_sat_dir", s_dir, 0);
    // acc must have cleared at the saturated end: 4 cw now steps exactly once.
    repeat (3) pulse(1, 0, 0, 1, 1);
    q_s.push_back({1'b1, 8'd1});
    pulse(1, 0, 0, 1, 1);
    check("t2_sat_acc_cleared", s_chan, 1);

    // 3 cw, 2 ccw, 3 cw: single step on the last cw.
    do_reset();
    repeat (3) pulse(1, 0, 1, 0, 1);
    repeat (2) pulse(0, 1, 1, 0, 1);
    repeat (2) pulse(1, 0, 1, 0, 1);
    check("t3_no_early_step", m_chan, 0);
    q_m.push_back({1'b1, 8'd1});
    pulse(1, 0, 1, 0, 1);
    check("t3_chan", m_chan, 1);

    // Conflict cycle is flagged and does not move acc.
    do_reset();
    pulse(1, 1, 1, 0, 1);
    check("t4_conflict_set", m_conflict, 1);
    repeat (3) pulse(1, 0, 1, 0, 1);
    check("t4_acc_unaffected", m_chan, 0);
    q_m.push_back({1'b1, 8'd1});
    pulse(1, 0, 1, 0, 1);
    check("t4_chan", m_chan, 1);
    check("t4_conflict_sticky", m_conflict, 1);

    // Second change 8 cycles after the first restarts the settle window.
    do_reset();
    repeat (3) pulse(1, 0, 1, 0, 0);
    q_m.push_back({1'b1, 8'd1});
    pulse(1, 0, 1, 0, 0);
    repeat (4) tick();
    repeat (3) pulse(1, 0, 1, 0, 0);
    q_m.push_back({1'b1, 8'd2});
    pulse(1, 0, 1, 0, 0);
    check("t5_chan", m_chan, 2);
    repeat (15) tick();
    check("t5_window_restarted", m_settled, 0);
    tick();
    check("t5_settled_after_restart", m_settled, 1);
    // Reset in the middle of a window.
    repeat (3) pulse(1, 0, 1, 0, 0);
    q_m.push_back({1'b1, 8'd3});
    pulse(1, 0, 1, 0, 0);
    repeat (5) tick();
    do_reset();
    check("t5_rst_chan", m_chan, 0);
    check("t5_rst_settled", m_settled, 0);
    check("t5_rst_changed", m_changed, 0);
    check("t5_rst_conflict", m_conflict, 0);
    check("t5_rst_dir", m_dir, 1);
    repeat (15) tick();
    check("t5_rst_cnt_full", m_settled, 0);
    tick();
    check("t5_rst_cnt_done", m_settled, 1);

`ifdef ENC_CHAN_LOAD_EN
    // Load wins over a simultaneous 4th cw and clears acc; out-of-range loads are ignored.
    do_reset();
    repeat (3) pulse(1, 0, 0, 1, 0);
    s_load_en = 1'b1; s_load_chan = 4'd5;
    q_s.push_back({1'b1, 8'd5});
    pulse(1, 0, 0, 1, 0);
    s_load_en = 1'b0;
    check("t6_load_chan", s_chan, 5);
    repeat (3) pulse(1, 0, 0, 1, 0);
    check("t6_load_cleared_acc", s_chan, 5);
    s_load_en = 1'b1; s_load_chan = 4'd9;
    q_s.push_back({1'b1, 8'd6});
    pulse(1, 0, 0, 1, 0);
    check("t6_bad_load_enc_step", s_chan, 6);
    pulse(0, 0, 0, 1, 0);
    s_load_en = 1'b0;
    check("t6_bad_load_ignored", s_chan, 6);
    check("t6_bad_load_dir", s_dir, 1);
    s_load_en = 1'b1; s_load_chan = 4'd6;
    pulse(0, 0, 0, 1, 1);
    s_load_en = 1'b0;
    check("t6_same_load_chan", s_chan, 6);
    check("t6_same_load_dir", s_dir, 0);
`endif

    repeat (3) tick();
    check("main_queue_empty", q_m.size(), 0);
    check("sat_queue_empty", q_s.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
